// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: job sequencer for the 2D MAC tile array.
// Runs clear -> (weight load -> kernel propagate, WS only) -> execute -> drain
// for each accepted job and drives the array, L0 and output FIFO strobes.
module mac_array_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_nij = 16,
    parameter int cnt_bw  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    input  logic       l0_ready,
    input  logic       ofifo_full,
    output logic [1:0] inst_w,
    output logic       mode_select,
    output logic       arr_reset,
    output logic       l0_rd,
    output logic       ofifo_wr,
    output logic       busy,
    output logic       done,
    output logic       ovf_err
);

    typedef enum logic [2:0] {
        IDLE, CLR, WAITL, LOAD, GAP, EXEC, DRAIN, DONE
    } state_t;

    // Last index of each counted phase, and the output-write window on e.
    localparam logic [cnt_bw-1:0] ROW_LAST = cnt_bw'(row - 1);
    localparam logic [cnt_bw-1:0] COL_LAST = cnt_bw'(col - 1);
    localparam logic [cnt_bw-1:0] NIJ_LAST = cnt_bw'(len_nij - 1);
    localparam logic [cnt_bw-1:0] LAT      = cnt_bw'(row + col - 1);
    localparam logic [cnt_bw-1:0] WR_LAST  = cnt_bw'(row + col - 2 + len_nij);

    state_t            state, nxt;
    logic [cnt_bw-1:0] cnt, cnt_n;   // LOAD / GAP beat counter
    logic [cnt_bw-1:0] e, e_n;       // cycles since first EXEC beat
    logic              mode_q, mode_n;

    // Next-state, counter and mode-latch decisions for the current state.
    always_comb begin
        nxt    = state;
        cnt_n  = cnt;
        e_n    = e;
        mode_n = mode_q;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt    = CLR;
                    mode_n = mode;
                end
            end
            CLR: begin
                cnt_n = '0;
                e_n   = '0;
                if (!l0_ready) nxt = WAITL;
                else           nxt = mode_q ? EXEC : LOAD;
            end
            WAITL: begin
                if (l0_ready) nxt = mode_q ? EXEC : LOAD;
            end
            LOAD: begin
                if (cnt == ROW_LAST) begin
                    nxt   = GAP;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + cnt_bw'(1);
                end
            end
            GAP: begin
                // The last gap beat is held until L0 can feed a full pass.
                if (cnt == COL_LAST) begin
                    if (l0_ready) nxt = EXEC;
                end else begin
                    cnt_n = cnt + cnt_bw'(1);
                end
            end
            EXEC: begin
                e_n = e + cnt_bw'(1);
                if (e == NIJ_LAST) nxt = DRAIN;
            end
            DRAIN: begin
                e_n = e + cnt_bw'(1);
                if (e == WR_LAST) nxt = DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State/counter register with Moore outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            e           <= '0;
            mode_q      <= 1'b0;
            inst_w      <= 2'b00;
            mode_select <= 1'b0;
            arr_reset   <= 1'b0;
            l0_rd       <= 1'b0;
            ofifo_wr    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            state       <= nxt;
            cnt         <= cnt_n;
            e           <= e_n;
            mode_q      <= mode_n;
            inst_w      <= {nxt == EXEC, nxt == LOAD};
            mode_select <= (nxt != IDLE) && mode_n;
            arr_reset   <= (nxt == CLR);
            l0_rd       <= (nxt == LOAD) || (nxt == EXEC);
            ofifo_wr    <= ((nxt == EXEC) || (nxt == DRAIN)) &&
                           (e_n >= LAT) && (e_n <= WR_LAST);
            busy        <= (nxt != IDLE);
            done        <= (nxt == DONE);
            // Overflow is only flagged; the write itself still goes out.
            ovf_err     <= ovf_err || (ofifo_wr && ofifo_full);
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: directed + randomized job stream for mac_array_ctrl,
// expected outputs derived from the job timeline arithmetic.
module tb_mac_array_ctrl;

    localparam int ROW     = 8;
    localparam int COL     = 8;
    localparam int NIJ     = 16;
    localparam int LAT     = ROW + COL - 1;
    localparam int SZ      = 2200;
    localparam int RAND_LO = 410;
    localparam int RAND_HI = 2000;

    logic       clk = 1'b0;
    logic       reset, start, mode, l0_ready, ofifo_full;
    logic [1:0] inst_w;
    logic       mode_select, arr_reset, l0_rd, ofifo_wr, busy, done, ovf_err;

    bit         start_a[SZ];
    bit         mode_a[SZ];
    bit         l0_a[SZ];
    bit         full_a[SZ];
    bit         rst_a[SZ];
    logic [8:0] exp_a[SZ];
    logic [8:0] sb_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_array_ctrl #(
        .row(ROW), .col(COL), .len_nij(NIJ), .cnt_bw(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .l0_ready(l0_ready), .ofifo_full(ofifo_full),
        .inst_w(inst_w), .mode_select(mode_select), .arr_reset(arr_reset),
        .l0_rd(l0_rd), .ofifo_wr(ofifo_wr), .busy(busy), .done(done),
        .ovf_err(ovf_err)
    );

    // Output vector of a job at cycle k; bit0 (ovf_err) is filled in separately.
    function automatic logic [8:0] job_out(int k, int t, bit m, int L, int X, int D);
        bit ld, ex, wr;
        ld = (m == 1'b0) && (k >= L) && (k < L + ROW);
        ex = (k >= X) && (k < X + NIJ);
        wr = (k >= X + LAT) && (k < X + LAT + NIJ);
        return {ex, ld, m, (k == t + 1), ld | ex, wr, 1'b1, (k == D), 1'b0};
    endfunction

    task automatic build_stimulus();
        for (int c = 0; c < SZ; c++) begin
            start_a[c] = 0; mode_a[c] = 0; l0_a[c] = 1; full_a[c] = 0; rst_a[c] = 0;
        end
        for (int c = 0; c < 3; c++) rst_a[c] = 1;
        start_a[5] = 1;                                  // WS job, no stalls
        start_a[60] = 1; mode_a[60] = 1;                 // OS job
        start_a[100] = 1;                                // WS job, L0 late
        for (int c = 100; c < 105; c++) l0_a[c] = 0;
        start_a[160] = 1; full_a[200] = 1;               // WS job, FIFO full at c40
        start_a[220] = 1; rst_a[245] = 1; start_a[247] = 1;  // reset mid-EXEC
        for (int c = 300; c <= 350; c++) start_a[c] = 1; // start held high
        for (int c = RAND_LO; c < RAND_HI; c++) begin
            start_a[c] = ($urandom_range(0, 3) == 0);
            mode_a[c]  = $urandom_range(0, 1) == 1;
            l0_a[c]    = ($urandom_range(0, 3) != 0);
            full_a[c]  = ($urandom_range(0, 7) == 0);
            rst_a[c]   = ($urandom_range(0, 299) == 0);
        end
    endtask

    task automatic build_expected();
        bit active, m, ovf;
        int t, L, X, D, k;
        active = 0; ovf = 0; t = 0; m = 0; L = 0; X = 0; D = 0;
        exp_a[0] = '0;
        for (int c = 0; c < SZ - 1; c++) begin
            if (rst_a[c]) begin
                active = 0;
                ovf = 0;
                exp_a[c + 1] = '0;
            end else begin
                if (exp_a[c][3] && full_a[c]) ovf = 1;
                if (!active) begin
                    if (start_a[c]) begin
                        active = 1; t = c; m = mode_a[c];
                        k = t + 1;
                        while (k < SZ - 1 && !l0_a[k]) k++;
                        if (m == 1'b0) begin
                            L = k + 1;
                            k = L + ROW + COL - 1;
                            while (k < SZ - 1 && !l0_a[k]) k++;
                            X = k + 1;
                        end else begin
                            L = -1000;
                            X = k + 1;
                        end
                        D = X + LAT + NIJ;
                    end
                end else if (c == D) begin
                    active = 0;
                end
                exp_a[c + 1] = active ? job_out(c + 1, t, m, L, X, D) : 9'b0;
                exp_a[c + 1][0] = ovf;
            end
        end
    endtask

    // Stimulus: drive cycle c and post the response due in cycle c+1.
    initial begin
        build_stimulus();
        build_expected();
        for (int c = 0; c < SZ - 1; c++) begin
            reset      = rst_a[c];
            start      = start_a[c];
            mode       = mode_a[c];
            l0_ready   = l0_a[c];
            ofifo_full = full_a[c];
            sb_q.push_back(exp_a[c + 1]);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Monitor: every cycle the DUT presents a full output vector.
    initial begin
        int         cyc;
        logic [8:0] act, expv;
        cyc = 1;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                expv = sb_q.pop_front();
                act  = {inst_w, mode_select, arr_reset, l0_rd, ofifo_wr, busy, done, ovf_err};
                checks++;
                if (act !== expv) begin
                    errors++;
                    $display("FAIL cycle_%0d outputs {inst_w,msel,arr_rst,l0_rd,wr,busy,done,ovf}: got %b required %b",
                             cyc, act, expv);
                end
                cyc++;
            end
        end
    end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the 2D MAC tile array. It drives the array's west-edge instruction bus, mode select and array reset, reads the L0 input buffer and writes the output FIFO. For each job it runs the phase sequence clear → (weight load → kernel propagate, WS only) → execute → drain, then returns to idle. It sits between the top-level core control and the array, replacing hand-sequenced testbench stimulus.

## Interface
Parameters:
- row, 8: number of array rows; WS weight-load beats.
- col, 8: number of array columns; kernel propagation gap, in cycles.
- len_nij, 16: activation vectors per execute pass.
- cnt_bw, 8: phase counter width; must hold row+col-1+len_nij.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- mode  in  1  0 = weight stationary (WS), 1 = output stationary (OS); latched on accepted start.
- l0_ready  in  1  L0 holds at least one full phase of vectors.
- ofifo_full  in  1  output FIFO full.
- inst_w  out  2  array instruction: bit1 execute, bit0 kernel load.
- mode_select  out  1  to every tile.
- arr_reset  out  1  array reset.
- l0_rd  out  1  L0 read enable.
- ofifo_wr  out  1  output FIFO write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- ovf_err  out  1  sticky; ofifo_wr asserted while ofifo_full.

## Operation
- States: IDLE, CLR, WAITL, LOAD, GAP, EXEC, DRAIN, DONE.
- All outputs are registered Moore outputs, decoded from the state register.
- Reset value of every output is 0. State resets to IDLE; all counters and the latched mode reset to 0.
- IDLE: when start=1, latch mode and go to CLR. start in any other state is ignored.
- CLR: one cycle. arr_reset=1.
  - Go to WAITL if l0_ready=0.
  - Otherwise go to LOAD (WS) or EXEC (OS).
- WAITL: all outputs idle except busy. Leave for LOAD (WS) or EXEC (OS) in the cycle after l0_ready=1.
- LOAD (WS only): row cycles with inst_w=01 and l0_rd=1.
- GAP (WS only): col cycles with inst_w=00.
  - On the final count, hold GAP while l0_ready=0.
  - Go to EXEC in the cycle after l0_ready=1.
- EXEC: len_nij cycles with inst_w=10 and l0_rd=1. l0_ready is not re-checked; phases are never interrupted once entered.
- Drain window:
  - Counter e=0 at the first EXEC cycle, incrementing every cycle through EXEC and DRAIN.
  - LAT = row+col-1.
  - ofifo_wr=1 exactly for e in [LAT, LAT+len_nij-1], regardless of state (EXEC or DRAIN).
  - EXEC→DRAIN after the last execute beat. DRAIN→DONE when e = LAT+len_nij.
- DONE: one cycle, done=1, busy=1. Then go to IDLE.
- mode_select equals the latched mode from CLR through DONE. It is 0 in IDLE.
- ovf_err: set when ofifo_wr=1 and ofifo_full=1 in the same cycle. Writes are not withheld. Cleared only by reset.
- Reset mid-operation: synchronous return to IDLE with all outputs 0 in the next cycle. The array is re-cleared by the next job's CLR.

## Timing
- Throughput: one job in flight. A start in the DONE cycle is ignored; start is accepted the cycle after DONE.
- Start accepted at cycle t → CLR at t+1.
- WS, no stalls:
  - LOAD t+2..t+row+1.
  - GAP next col cycles.
  - EXEC next len_nij cycles.
- OS, no stalls: EXEC starts at t+2.
- First ofifo_wr occurs LAT cycles after the first EXEC cycle.
- Each WAITL/GAP stall cycle shifts all later events by exactly 1 cycle.
- Job totals:
  - l0_rd pulses: row+len_nij (WS) or len_nij (OS).
  - ofifo_wr pulses: len_nij.
  - done pulses: 1.

## Test plan
- WS job (defaults), start at cycle 0, l0_ready=1:
  - arr_reset at c1.
  - inst_w=01 c2–c9.
  - inst_w=00 c10–c17.
  - inst_w=10 c18–c33.
  - ofifo_wr c33–c48.
  - done at c49; busy low from c50.
  - 24 l0_rd pulses.
- OS job, start at c0:
  - mode_select=1 c1–c33.
  - EXEC c2–c17.
  - ofifo_wr c17–c32.
  - done at c33.
  - 16 l0_rd pulses.
- WS job with l0_ready low until c5 (high from c5): stays in WAITL; LOAD c6–c13; done at c53.
- ofifo_full=1 at c40 in the WS job: ovf_err=1 from c41 and stays 1 after done; write count still 16.
- reset at c25 during WS EXEC: at c26 all outputs 0 and busy=0. A new start at c27 gives arr_reset at c28.
- start held high during a whole WS job: exactly one job runs. The second job begins only when start is seen in IDLE at c50 (CLR at c51).
